// File: rtl/serial_sub_n.sv
// serial_sub_n: bit-serial a - b - bin over WIDTH cycles.
// One full-subtract cell, registered borrow, start/busy/done handshake.
module serial_sub_n #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic             r_br;
  logic             r_a_msb;
  logic             r_b_msb;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_ovf;

  logic             w_d;
  logic             w_br_nx;
  logic             w_last;
  logic [WIDTH-1:0] w_sh_nx;

  assign w_d     = r_a_sh[0] ^ r_b_sh[0] ^ r_br;
  assign w_br_nx = (~r_a_sh[0] & r_b_sh[0])
                 | (~(r_a_sh[0] ^ r_b_sh[0]) & r_br);
  assign w_last  = (r_cnt == LAST);

  // Result bits fill the minuend register from the MSB as it drains
  generate
    if (WIDTH == 1) begin : g_w1
      assign w_sh_nx = w_d;
    end else begin : g_wn
      assign w_sh_nx = {w_d, r_a_sh[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_br    <= 1'b0;
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_cnt   <= '0;
      r_diff  <= '0;
      r_bout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (r_state == S_IDLE && start) begin
      r_a_sh  <= a;
      r_b_sh  <= b;
      r_br    <= bin;
      r_a_msb <= a[WIDTH-1];
      r_b_msb <= b[WIDTH-1];
      r_cnt   <= '0;
    end else if (r_state == S_RUN) begin
      r_a_sh <= w_sh_nx;
      r_b_sh <= r_b_sh >> 1;
      r_br   <= w_br_nx;
      r_cnt  <= r_cnt + 1'b1;
      if (w_last) begin
        r_diff <= w_sh_nx;
        r_bout <= w_br_nx;
        r_ovf  <= (r_a_msb != r_b_msb)
                & (w_sh_nx[WIDTH-1] != r_a_msb);
      end
    end
  end

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);
  assign diff = r_diff;
  assign bout = r_bout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_sub_n.sv
// tb_serial_sub_n: directed and reference-model checks
// for serial_sub_n at WIDTH 1, 8, 16 and 64.
module tb_serial_sub_n;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        go;
  int          sel;
  logic [63:0] a;
  logic [63:0] b;
  logic        bin;

  always #5 clk = ~clk;

  logic        busy1, done1, bout1, ovf1;
  logic [0:0]  diff1;
  logic        busy8, done8, bout8, ovf8;
  logic [7:0]  diff8;
  logic        busy16, done16, bout16, ovf16;
  logic [15:0] diff16;
  logic        busy64, done64, bout64, ovf64;
  logic [63:0] diff64;

  serial_sub_n #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(go && sel == 1),
    .a(a[0:0]), .b(b[0:0]), .bin(bin),
    .busy(busy1), .done(done1), .diff(diff1),
    .bout(bout1), .ovf(ovf1)
  );

  serial_sub_n #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(go && sel == 8),
    .a(a[7:0]), .b(b[7:0]), .bin(bin),
    .busy(busy8), .done(done8), .diff(diff8),
    .bout(bout8), .ovf(ovf8)
  );

  serial_sub_n #(.WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n), .start(go && sel == 16),
    .a(a[15:0]), .b(b[15:0]), .bin(bin),
    .busy(busy16), .done(done16), .diff(diff16),
    .bout(bout16), .ovf(ovf16)
  );

  serial_sub_n #(.WIDTH(64)) u64 (
    .clk(clk), .rst_n(rst_n), .start(go && sel == 64),
    .a(a), .b(b), .bin(bin),
    .busy(busy64), .done(done64), .diff(diff64),
    .bout(bout64), .ovf(ovf64)
  );

  logic        m_busy, m_done, m_bout, m_ovf;
  logic [63:0] m_diff;

  always_comb begin
    m_busy = 1'b0;
    m_done = 1'b0;
    m_bout = 1'b0;
    m_ovf  = 1'b0;
    m_diff = '0;
    case (sel)
      1: begin
        m_busy = busy1; m_done = done1; m_bout = bout1;
        m_ovf = ovf1; m_diff = 64'(diff1);
      end
      8: begin
        m_busy = busy8; m_done = done8; m_bout = bout8;
        m_ovf = ovf8; m_diff = 64'(diff8);
      end
      16: begin
        m_busy = busy16; m_done = done16; m_bout = bout16;
        m_ovf = ovf16; m_diff = 64'(diff16);
      end
      64: begin
        m_busy = busy64; m_done = done64; m_bout = bout64;
        m_ovf = ovf64; m_diff = diff64;
      end
      default: ;
    endcase
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_op(input int w, input logic [63:0] ia,
                        input logic [63:0] ib, input logic ibin,
                        input logic [63:0] ed, input logic eb,
                        input logic eo);
    int lat;
    int nbusy;
    @(negedge clk);
    sel = w;
    a   = ia;
    b   = ib;
    bin = ibin;
    go  = 1'b1;
    @(posedge clk);
    #1 go = 1'b0;
    a   = ~ia;
    b   = ~ib;
    bin = ~ibin;
    lat   = 0;
    nbusy = 0;
    for (int i = 0; i < w + 5; i++) begin
      @(negedge clk);
      if (m_done) break;
      if (m_busy) nbusy++;
      @(posedge clk);
      lat++;
    end
    chk($sformatf("w%0d latency", w), 64'(lat), 64'(w));
    chk($sformatf("w%0d busy_cycles", w), 64'(nbusy), 64'(w));
    chk($sformatf("w%0d busy_in_done", w), 64'(m_busy), 64'd0);
    chk($sformatf("w%0d diff", w), m_diff, ed);
    chk($sformatf("w%0d bout", w), 64'(m_bout), 64'(eb));
    chk($sformatf("w%0d ovf", w), 64'(m_ovf), 64'(eo));
    @(negedge clk);
    chk($sformatf("w%0d done_pulse", w), 64'(m_done), 64'd0);
  endtask

  task automatic model(input int w, input logic [63:0] ia,
                       input logic [63:0] ib, input logic ibin,
                       output logic [63:0] ed, output logic eb,
                       output logic eo);
    logic [63:0]        mask;
    logic [63:0]        ax, bx;
    logic [64:0]        u;
    logic signed [63:0] ta, tb;
    logic signed [66:0] sa, sb, sr, lim;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    ax   = ia & mask;
    bx   = ib & mask;
    u    = {1'b0, ax} - {1'b0, bx} - 65'(ibin);
    ed   = u[63:0] & mask;
    eb   = u[64];
    ta   = $signed(ax << (64 - w));
    ta   = ta >>> (64 - w);
    tb   = $signed(bx << (64 - w));
    tb   = tb >>> (64 - w);
    sa   = ta;
    sb   = tb;
    sr   = sa - sb - (ibin ? 67'sd1 : 67'sd0);
    lim  = 67'sd1 <<< (w - 1);
    eo   = (sr >= lim) || (sr < -lim);
  endtask

  logic [7:0]  dtab;
  logic [7:0]  btab;
  logic [7:0]  otab;
  logic [2:0]  v;
  logic [63:0] ra, rb, ed;
  logic        rbin, eb, eo;
  int          ndone, nbusy;
  logic [63:0] cdiff;
  logic        cbout, covf;

  initial begin
    rst_n = 1'b0;
    go    = 1'b0;
    sel   = 8;
    a     = '0;
    b     = '0;
    bin   = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst busy", 64'(m_busy), 64'd0);
    chk("rst done", 64'(m_done), 64'd0);
    chk("rst diff", m_diff, 64'd0);
    chk("rst bout", 64'(m_bout), 64'd0);
    chk("rst ovf", 64'(m_ovf), 64'd0);
    rst_n = 1'b1;

    run_op(8, 64'h05, 64'h03, 1'b0, 64'h02, 1'b0, 1'b0);
    run_op(8, 64'h03, 64'h05, 1'b0, 64'hFE, 1'b1, 1'b0);
    run_op(8, 64'h00, 64'h00, 1'b1, 64'hFF, 1'b1, 1'b0);
    run_op(8, 64'h80, 64'h01, 1'b0, 64'h7F, 1'b0, 1'b1);
    run_op(8, 64'h7F, 64'hFF, 1'b0, 64'h80, 1'b1, 1'b1);

    // start raised again mid-run must be ignored
    @(negedge clk);
    sel = 8;
    a   = 64'h10;
    b   = 64'h01;
    bin = 1'b0;
    go  = 1'b1;
    @(posedge clk);
    #1 go = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a  = 64'hFF;
    b  = 64'h00;
    go = 1'b1;
    @(posedge clk);
    #1 go = 1'b0;
    a  = 64'h3C;
    b  = 64'h5A;
    ndone = 0;
    cdiff = '0;
    cbout = 1'b0;
    covf  = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (m_done) begin
        ndone++;
        if (ndone == 1) begin
          cdiff = m_diff;
          cbout = m_bout;
          covf  = m_ovf;
        end
      end
    end
    chk("ign ndone", 64'(ndone), 64'd1);
    chk("ign diff", cdiff, 64'h0F);
    chk("ign bout", 64'(cbout), 64'd0);
    chk("ign ovf", 64'(covf), 64'd0);

    // asynchronous abort mid-run
    @(negedge clk);
    a  = 64'h55;
    b  = 64'h22;
    go = 1'b1;
    @(posedge clk);
    #1 go = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort busy", 64'(m_busy), 64'd0);
    chk("abort done", 64'(m_done), 64'd0);
    chk("abort diff", m_diff, 64'd0);
    chk("abort bout", 64'(m_bout), 64'd0);
    chk("abort ovf", 64'(m_ovf), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    nbusy = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (m_done) ndone++;
      if (m_busy) nbusy++;
    end
    chk("abort ndone", 64'(ndone), 64'd0);
    chk("abort nbusy", 64'(nbusy), 64'd0);
    run_op(8, 64'h09, 64'h09, 1'b0, 64'h00, 1'b0, 1'b0);

    // 1-bit full-subtractor table, indexed by {a,b,bin}
    dtab = 8'b1001_0110;
    btab = 8'b1000_1110;
    otab = 8'b0010_0100;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      run_op(1, 64'(v[2]), 64'(v[1]), v[0],
             64'(dtab[i]), btab[i], otab[i]);
    end

    for (int i = 0; i < 6; i++) begin
      ra   = {$urandom, $urandom};
      rb   = {$urandom, $urandom};
      rbin = 1'($urandom_range(0, 1));
      model(16, ra, rb, rbin, ed, eb, eo);
      run_op(16, ra, rb, rbin, ed, eb, eo);
      ra   = {$urandom, $urandom};
      rb   = {$urandom, $urandom};
      rbin = 1'($urandom_range(0, 1));
      model(64, ra, rb, rbin, ed, eb, eo);
      run_op(64, ra, rb, rbin, ed, eb, eo);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
